regfile_dump_tx: RTL and testbench

- Debug readout engine for the miniRISC core: on request, walks a range of register-file entries through a dedicated read port and streams them out as a framed byte stream over a valid/ready interface.
- Gives hardware (UART bridge, logic analyser, host link) the same view of final register state that the simulation bench gets by peeking the register file.
- Sits beside the datapath register file; drives only its secondary read port.

---
 rtl/regfile_dump_tx.sv | 144 ++++++++++++++
 tb/tb_regfile_dump_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: debug readout engine. On request it walks an inclusive range of
// register-file entries through the secondary read port. It streams them out as a
// framed byte stream: header, then {addr, d[7:0], d[15:8], d[23:16], d[31:24]} per
// register, then an XOR checksum of every byte after the header.
module regfile_dump_tx #(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_READ,
    S_CAPT,
    S_SEND,
    S_CHK,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_end;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_idx;
  logic [7:0]        r_csum;

  logic              w_xfer;
  logic [7:0]        w_addr_byte;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_xfer      = tx_valid & tx_ready;
  assign w_addr_byte = 8'(r_cur);
  assign w_next_addr = r_cur + 1'b1;

  // Single FSM: every output is registered and loaded on the edge that enters the
  // state presenting it. tx_valid therefore never depends combinationally on tx_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cur    <= '0;
      r_end    <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_csum   <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur  <= start_addr;
            r_end  <= end_addr;
            r_csum <= '0;
            busy   <= 1'b1;
            if (start_addr > end_addr) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state  <= S_HDR;
              tx_data  <= HDR_BYTE;
              tx_valid <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= r_cur;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          rd_en   <= 1'b0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_shift  <= rd_data;
          r_idx    <= '0;
          tx_data  <= w_addr_byte;
          tx_valid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ tx_data;
            if (r_idx == 3'd4) begin
              // The end compare uses cur before any increment, so a range ending
              // at NUM_REGS-1 stops there instead of wrapping to 0.
              if (r_cur == r_end) begin
                tx_data <= r_csum ^ tx_data;
                r_state <= S_CHK;
              end else begin
                r_cur    <= w_next_addr;
                tx_valid <= 1'b0;
                rd_en    <= 1'b1;
                rd_addr  <= w_next_addr;
                r_state  <= S_READ;
              end
            end else begin
              tx_data <= r_shift[7:0];
              r_shift <= r_shift >> 8;
              r_idx   <= r_idx + 3'd1;
            end
          end
        end
        S_CHK: begin
          if (w_xfer) begin
            tx_valid <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Directed bench for regfile_dump_tx: a register-file model answers reads, and a
// negedge monitor records transferred bytes, read strobes, done pulses and stalls.
module tb_regfile_dump_tx;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  start_addr;
  logic [4:0]  end_addr;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic [7:0]  q [$];
  logic [7:0]  expq [$];
  int          done_cnt, rd_cnt, stab_err, vcnt;
  logic        saw0;
  logic [4:0]  last_rd;
  logic        rnd_ready;
  logic        prev_stall;
  logic [7:0]  prev_data;

  regfile_dump_tx #(
    .NUM_REGS (32),
    .ADDR_W   (5),
    .DATA_W   (32),
    .HDR_BYTE (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: data valid the cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // pseudo-random sink backpressure
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // monitor: values sampled mid-cycle are those the next rising edge acts on
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid) vcnt++;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (done) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        last_rd = rd_addr;
        if (rd_addr == 5'd0) saw0 = 1'b1;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt   = 0;
    rd_cnt     = 0;
    stab_err   = 0;
    vcnt       = 0;
    saw0       = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] s, input logic [4:0] e);
    @(posedge clk); #1;
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, q.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < q.size()) check($sformatf("%s_b%0d", tag, i), q[i], expq[i]);
    end
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] d;

    rst        = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    tx_ready   = 1'b1;
    rnd_ready  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    mem[3]  = 32'h12345678;
    mem[30] = 32'h00000000;
    mem[31] = 32'hFFFFFFFF;
    clear_mon();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data",  tx_data,  0);
    check("rst_busy",     busy,     0);
    check("rst_done",     done,     0);
    check("rst_rd_en",    rd_en,    0);
    check("rst_rd_addr",  rd_addr,  0);
    rst = 1'b1;

    // single register 3..3
    clear_mon();
    pulse_start(5'd3, 5'd3);
    check("t1_busy", busy, 1);
    wait_done("t1", 100);
    expq = '{8'hA5, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0B};
    cmp_stream("t1");
    check("t1_rd_cnt",  rd_cnt,   1);
    check("t1_rd_addr", last_rd,  3);
    check("t1_done",    done_cnt, 1);
    check("t1_busy_end", busy,    0);

    // top of the file, no wrap
    clear_mon();
    pulse_start(5'd30, 5'd31);
    wait_done("t2", 100);
    expq = '{8'hA5, 8'h1E, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    cmp_stream("t2");
    check("t2_rd_cnt", rd_cnt,   2);
    check("t2_no_wrap", saw0,    0);
    check("t2_done",   done_cnt, 1);

    // empty range 5..4
    clear_mon();
    pulse_start(5'd5, 5'd4);
    repeat (2) @(posedge clk);
    #1;
    check("t3_done",   done_cnt, 1);
    check("t3_valid",  vcnt,     0);
    check("t3_rd_cnt", rd_cnt,   0);
    check("t3_busy",   busy,     0);

    // 3..3 with random backpressure
    clear_mon();
    rnd_ready = 1'b1;
    pulse_start(5'd3, 5'd3);
    wait_done("t4", 500);
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    tx_ready = 1'b1;
    expq = '{8'hA5, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0B};
    cmp_stream("t4");
    check("t4_stable", stab_err, 0);
    check("t4_done",   done_cnt, 1);

    // reset while the third payload byte is stalled
    clear_mon();
    pulse_start(5'd3, 5'd3);
    for (int n = 0; n < 50 && q.size() < 4; n++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_stall_valid", tx_valid, 1);
    check("t5_stall_data",  tx_data,  8'h34);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_valid", tx_valid, 0);
    check("t5_rst_busy",  busy,     0);
    check("t5_rst_done",  done,     0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    clear_mon();
    pulse_start(5'd3, 5'd3);
    wait_done("t5", 100);
    expq = '{8'hA5, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0B};
    cmp_stream("t5");

    // full dump 0..31, extra start while busy is ignored
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h01030507 + 32'h11;
    expq.delete();
    expq.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      d = mem[i];
      expq.push_back(8'(i));
      cs ^= 8'(i);
      for (int b = 0; b < 4; b++) begin
        expq.push_back(d[8*b +: 8]);
        cs ^= d[8*b +: 8];
      end
    end
    expq.push_back(cs);
    clear_mon();
    pulse_start(5'd0, 5'd31);
    repeat (40) @(posedge clk);
    pulse_start(5'd3, 5'd3);
    wait_done("t6", 1000);
    repeat (20) @(posedge clk);
    #1;
    check("t6_count", q.size(), 162);
    cmp_stream("t6");
    check("t6_done",   done_cnt, 1);
    check("t6_rd_cnt", rd_cnt,   32);
    check("t6_busy",   busy,     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
